// File: rtl/out_pkg.sv
// Shared sizing, state encoding and counter types for the out_ctrl block drain path.
package out_pkg;
  localparam int W     = 32;
  localparam int N     = 64;
  localparam int BANKS = 4;
  localparam int AW    = 8;
  localparam int NW    = $clog2(N);
  localparam int BW    = $clog2(BANKS);

  typedef enum logic {IDLE, DRAIN} out_state_t;
  typedef logic [NW:0]   idx_t;
  typedef logic [BW-1:0] bank_t;
endpackage

// File: rtl/out_skid.sv
// Two-entry skid FIFO between the dst_buff read return and the output stream.
module out_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [1:0]    o_count,
  output logic [DW-1:0] o_head
);
  logic [DW-1:0] r_mem [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/out_ctrl.sv
// Drains one N-word block from dst_buff onto a valid/ready stream per k_fin pulse.
// Optional OUT_LAST_EN adds blk_last/m_last job framing and a bank restart after the last block.
module out_ctrl
  import out_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          k_fin,
`ifdef OUT_LAST_EN
  input  logic          blk_last,
`endif
  output logic          dst_rd_en,
  output logic [AW-1:0] dst_rd_addr,
  input  logic [W-1:0]  dst_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
`ifdef OUT_LAST_EN
  output logic          m_last,
`endif
  output logic          out_busy,
  output logic          out_fin
);
`ifdef OUT_LAST_EN
  localparam int SW = W + 1;
`else
  localparam int SW = W;
`endif

  out_state_t    r_state;
  out_state_t    w_state_nxt;
  idx_t          r_idx;
  idx_t          r_beat;
  bank_t         r_bank;
  bank_t         w_bank_nxt;
  logic          r_inflight;
  logic          r_fin;
  logic          w_start;
  logic          w_active;
  logic          w_pop;
  logic          w_room;
  logic          w_acc_last;
  logic [2:0]    w_occ;
  logic [1:0]    w_count;
  logic [SW-1:0] w_push_data;
  logic [SW-1:0] w_head;

  assign w_start  = (r_state == IDLE) && k_fin;
  // The k_fin cycle already issues the first read so beat 0 appears two cycles later.
  assign w_active = (r_state == DRAIN) || w_start;
  assign w_pop    = m_valid && m_ready;
  assign w_occ    = {1'b0, w_count} + {2'b00, r_inflight};
  // A same-cycle pop frees a slot, which is what sustains one beat per cycle.
  assign w_room   = w_occ < (3'd2 + {2'b00, w_pop});

  assign dst_rd_en   = w_active && (r_idx < idx_t'(N)) && w_room;
  assign dst_rd_addr = {r_bank, r_idx[NW-1:0]};
  assign w_acc_last  = w_pop && (r_beat == idx_t'(N - 1));
  assign out_busy    = (r_state != IDLE) || k_fin;
  assign out_fin     = r_fin;
  assign m_valid     = (w_count != 2'd0);
  assign m_data      = m_valid ? w_head[W-1:0] : '0;

`ifdef OUT_LAST_EN
  logic r_last_blk;
  logic r_inflight_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_blk      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_start) r_last_blk <= blk_last;
      r_inflight_last <= dst_rd_en && r_last_blk && (r_idx == idx_t'(N - 1));
    end
  end

  assign w_push_data = {r_inflight_last, dst_rd_data};
  assign m_last      = m_valid && w_head[W];
  assign w_bank_nxt  = r_last_blk ? '0 : bank_t'(r_bank + 1'b1);
`else
  assign w_push_data = dst_rd_data;
  assign w_bank_nxt  = bank_t'(r_bank + 1'b1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (k_fin)      w_state_nxt = DRAIN;
      DRAIN:   if (w_acc_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_beat     <= '0;
      r_bank     <= '0;
      r_inflight <= 1'b0;
      r_fin      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= dst_rd_en;
      r_fin      <= w_acc_last;
      if (w_acc_last) begin
        r_idx  <= '0;
        r_beat <= '0;
        r_bank <= w_bank_nxt;
      end else begin
        if (dst_rd_en) r_idx  <= idx_t'(r_idx + 1'b1);
        if (w_pop)     r_beat <= idx_t'(r_beat + 1'b1);
      end
    end
  end

  out_skid #(.DW(SW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  a_kfin_drain: assert property (@(posedge clk) disable iff (rst) !((r_state == DRAIN) && k_fin))
    else $warning("out_ctrl: k_fin while draining was ignored");
endmodule

// File: tb/tb_out_ctrl.sv
// Scoreboard bench for out_ctrl: stimulus pushes expected beats, a negedge monitor pops and compares.
// Define OUT_LAST_EN for both RTL and bench to exercise job framing.
module tb_out_ctrl;
  import out_pkg::*;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         blk_end;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          k_fin;
  logic          dst_rd_en;
  logic [AW-1:0] dst_rd_addr;
  logic [W-1:0]  dst_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          out_busy;
  logic          out_fin;
`ifdef OUT_LAST_EN
  logic          blk_last;
  logic          m_last;
`endif

  exp_t         q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           bank_m = 0;
  logic         exp_fin = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  always #5 clk = ~clk;

  out_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .k_fin       (k_fin),
`ifdef OUT_LAST_EN
    .blk_last    (blk_last),
`endif
    .dst_rd_en   (dst_rd_en),
    .dst_rd_addr (dst_rd_addr),
    .dst_rd_data (dst_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
`ifdef OUT_LAST_EN
    .m_last      (m_last),
`endif
    .out_busy    (out_busy),
    .out_fin     (out_fin)
  );

  // dst_buff model: each word holds its own address, one-cycle read latency
  always @(posedge clk) begin
    if (dst_rd_en) dst_rd_data <= W'(dst_rd_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: fin timing, busy, stall stability, and scoreboard pops
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_fin    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (out_fin || exp_fin) check("out_fin", 64'(out_fin), 64'(exp_fin));
      exp_fin = 1'b0;
      check("out_busy", 64'(out_busy), 64'(k_fin || (q.size() != 0)));
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          check("extra_beat", 64'(m_data), 64'hdead);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("m_data", 64'(m_data), 64'(e.data));
`ifdef OUT_LAST_EN
          check("m_last", 64'(m_last), 64'(e.last));
`endif
          exp_fin = e.blk_end;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic push_block(input logic last);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data    = W'(bank_m * N + i);
      e.last    = last && (i == N - 1);
      e.blk_end = (i == N - 1);
      q.push_back(e);
    end
    bank_m = last ? 0 : (bank_m + 1) % BANKS;
  endtask

  // Call at posedge+#1; returns at the next posedge+#1 with k_fin low
  task automatic issue_kfin(input logic last);
    k_fin = 1'b1;
`ifdef OUT_LAST_EN
    blk_last = last;
`endif
    push_block(last);
    @(posedge clk); #1;
    k_fin = 1'b0;
`ifdef OUT_LAST_EN
    blk_last = 1'b0;
`endif
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fin_pos();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_fin && n < 600);
    if (!out_fin) check("fin_timeout", 64'(out_fin), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bank_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; k_fin = 1'b0; m_ready = 1'b1; dst_rd_data = '0;
`ifdef OUT_LAST_EN
    blk_last = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_fin", 64'(out_fin), 64'd0);
    check("rst_busy", 64'(out_busy), 64'd0);
    check("rst_rd_en", 64'(dst_rd_en), 64'd0);

    // Single block, m_ready high: latency and first read
    @(posedge clk); #1;
    k_fin = 1'b1;
    push_block(1'b0);
    @(negedge clk);
    check("t1_rd_en", 64'(dst_rd_en), 64'd1);
    check("t1_addr", 64'(dst_rd_addr), 64'd0);
    @(posedge clk); #1;
    k_fin = 1'b0;
    @(negedge clk);
    check("t1_valid_c1", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c2", 64'(m_valid), 64'd1);
    check("t1_data_c2", 64'(m_data), 64'd0);
    wait_drained();

    // Four back-to-back blocks from bank 0, k_fin in each out_fin cycle
    do_reset();
    issue_kfin(1'b0);
    for (int b = 1; b < 4; b++) begin
      wait_fin_pos();
      issue_kfin(1'b0);
    end
    wait_drained();

    // Backpressure: toggle then hold m_ready low; bank has wrapped to 0
    @(posedge clk); #1;
    k_fin = 1'b1;
    push_block(1'b0);
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      k_fin = 1'b0;
      m_ready = ~m_ready;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      m_ready = 1'b0;
      if (i == 9) begin
        @(negedge clk);
        check("t3_rd_pause", 64'(dst_rd_en), 64'd0);
        check("t3_valid_held", 64'(m_valid), 64'd1);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drained();

    // Stray k_fin around beat 20 must be ignored
    @(posedge clk); #1;
    issue_kfin(1'b0);
    repeat (21) @(posedge clk);
    #1;
    k_fin = 1'b1;
    @(posedge clk); #1;
    k_fin = 1'b0;
    wait_drained();
    repeat (4) @(negedge clk);

    // Reset around beat 30 aborts the block
    @(posedge clk); #1;
    issue_kfin(1'b0);
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    bank_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", 64'(m_valid), 64'd0);
    check("t5_busy_after_rst", 64'(out_busy), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    k_fin = 1'b1;
    push_block(1'b0);
    @(negedge clk);
    check("t5_restart_addr", 64'(dst_rd_addr), 64'd0);
    @(posedge clk); #1;
    k_fin = 1'b0;
    wait_drained();

`ifdef OUT_LAST_EN
    // Job framing: second block is last, third restarts at bank 0
    do_reset();
    issue_kfin(1'b0);
    wait_fin_pos();
    issue_kfin(1'b1);
    wait_fin_pos();
    k_fin = 1'b1;
    push_block(1'b0);
    @(negedge clk);
    check("t6_restart_addr", 64'(dst_rd_addr), 64'd0);
    @(posedge clk); #1;
    k_fin = 1'b0;
    wait_drained();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
